rom_arbiter: RTL

//  Shares one asynchronous ROM (tri-state data, active-low CE/OE) between two

---
 rtl/rom_arb_pkg.sv | 26 ++
 rtl/rom_arb_grant.sv | 27 ++
 rtl/rom_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM read arbiter.
// Build option: ROM_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
package rom_arb_pkg;

  // Strobe sequencing phases of one ROM read.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Requester index.
  typedef logic port_t;
  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

  // Legal range of the access time (clocks with OE_n low before sampling).
  localparam int TACC_MIN = 1;
  localparam int TACC_MAX = 15;

  function automatic bit tacc_ok(input int tacc);
    return (tacc >= TACC_MIN) && (tacc <= TACC_MAX);
  endfunction

endpackage

// File: rtl/rom_arb_grant.sv
// Combinational grant selection between the two read requesters.
// Build option: ROM_ARB_RR_EN -> on a tie the pointer port wins; otherwise port 0 always wins.
module rom_arb_grant
  import rom_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ptr,
  output logic o_valid,
  output logic o_port
);

  assign o_valid = i_req0 | i_req1;

`ifdef ROM_ARB_RR_EN
  // On a tie the pointer names the port that was not granted last.
  always_comb begin
    if (i_req0 && i_req1) o_port = i_ptr;
    else                  o_port = i_req1 ? PORT1 : PORT0;
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = i_ptr;
  assign o_port       = (i_req0 || !i_req1) ? PORT0 : PORT1;
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter for an asynchronous ROM: grants a port, drives CE_n/OE_n
// with a programmable access time, captures data and returns a one-cycle ack.
// Build option: ROM_ARB_RR_EN enables round-robin tie-breaking with a priority pointer.
// Handshake: a requester holds reqN high with addrN stable; the arbiter pulses ackN
// for one cycle with rdata valid. A request seen while busy waits for the next IDLE edge.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AWID = 18,
  parameter int DWID = 8,
  parameter int TACC = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic [AWID-1:0] addr0,
  output logic            ack0,
  input  logic            req1,
  input  logic [AWID-1:0] addr1,
  output logic            ack1,
  output logic [DWID-1:0] rdata,
  output logic            busy,
  output logic [AWID-1:0] rom_addr,
  input  logic [DWID-1:0] rom_data,
  output logic            rom_ce_n,
  output logic            rom_oe_n,
  output logic [1:0]      dbg_state
);

  localparam int            CW       = $clog2(TACC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TACC - 1);

  if (!tacc_ok(TACC)) begin : g_tacc_range
    $error("rom_arbiter: TACC must be within 1..15");
  end

  state_t          r_state,    w_state;
  logic [CW-1:0]   r_cnt,      w_cnt;
  logic            r_gnt,      w_gnt;
  logic            r_ack0,     w_ack0;
  logic            r_ack1,     w_ack1;
  logic [DWID-1:0] r_rdata,    w_rdata;
  logic [AWID-1:0] r_rom_addr, w_rom_addr;
  logic            r_ce_n,     w_ce_n;
  logic            r_oe_n,     w_oe_n;
  logic            w_ptr_cur;
  logic            w_gnt_valid;
  logic            w_gnt_port;

`ifdef ROM_ARB_RR_EN
  logic r_ptr, w_ptr;
  assign w_ptr_cur = r_ptr;
`else
  assign w_ptr_cur = PORT0;
`endif

  rom_arb_grant u_grant (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_ptr   (w_ptr_cur),
    .o_valid (w_gnt_valid),
    .o_port  (w_gnt_port)
  );

  // Next-state and next-output logic for the read sequencer.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_gnt      = r_gnt;
    w_rdata    = r_rdata;
    w_rom_addr = r_rom_addr;
    w_ce_n     = r_ce_n;
    w_oe_n     = r_oe_n;
    w_ack0     = 1'b0;
    w_ack1     = 1'b0;
`ifdef ROM_ARB_RR_EN
    w_ptr      = r_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_gnt      = w_gnt_port;
          w_rom_addr = w_gnt_port ? addr1 : addr0;
          w_ce_n     = 1'b0;
          w_state    = SETUP;
`ifdef ROM_ARB_RR_EN
          w_ptr      = ~w_gnt_port;
`endif
        end
      end
      SETUP: begin
        w_oe_n  = 1'b0;
        w_cnt   = CNT_LOAD;
        w_state = ACCESS;
      end
      ACCESS: begin
        // Both strobes are low here, so rom_data is driven by the ROM.
        if (r_cnt == '0) begin
          w_rdata = rom_data;
          w_ack0  = (r_gnt == PORT0);
          w_ack1  = (r_gnt == PORT1);
          w_ce_n  = 1'b1;
          w_oe_n  = 1'b1;
          w_state = DONE;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_gnt      <= PORT0;
      r_rdata    <= '0;
      r_rom_addr <= '0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
`ifdef ROM_ARB_RR_EN
      r_ptr      <= PORT0;
`endif
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_gnt      <= w_gnt;
      r_rdata    <= w_rdata;
      r_rom_addr <= w_rom_addr;
      r_ce_n     <= w_ce_n;
      r_oe_n     <= w_oe_n;
      r_ack0     <= w_ack0;
      r_ack1     <= w_ack1;
`ifdef ROM_ARB_RR_EN
      r_ptr      <= w_ptr;
`endif
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata     = r_rdata;
  assign rom_addr  = r_rom_addr;
  assign rom_ce_n  = r_ce_n;
  assign rom_oe_n  = r_oe_n;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule
